// File: rtl/wavegen_cfg_if.sv
// Configuration write port of the multi-channel DDS/PWM waveform generator.
// The controller side drives a one-cycle write strobe with the target channel and its settings.
interface wavegen_cfg_if #(
  parameter int PW = 16
) ();
  logic          cfg_we;
  logic [2:0]    cfg_ch;
  logic [2:0]    cfg_mode;
  logic [PW-1:0] cfg_inc;
  logic          cfg_pclr;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_mode,
    output cfg_inc,
    output cfg_pclr
  );

  modport slave (
    input cfg_we,
    input cfg_ch,
    input cfg_mode,
    input cfg_inc,
    input cfg_pclr
  );
endinterface

// File: rtl/wavegen_dds_pwm.sv
// Multi-channel DDS waveform generator with PWM outputs on a shared 2^DW-cycle frame.
// Config writes land in shadow registers and become active only at the frame boundary.
module wavegen_dds_pwm #(
  parameter int NCH = 2,
  parameter int DW  = 8,
  parameter int PW  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  wavegen_cfg_if.slave   cfg,
  output logic [NCH-1:0] pwm,
  output logic [NCH-1:0] sync,
  output logic           frame
);

  localparam logic [2:0]    MODE_SINE = 3'd1;
  localparam logic [2:0]    MODE_SAW  = 3'd2;
  localparam logic [2:0]    MODE_TRI  = 3'd3;
  localparam logic [2:0]    MODE_SQR  = 3'd4;
  localparam logic [2:0]    MODE_DC   = 3'd5;
  localparam logic [DW-1:0] CNT_MAX   = {DW{1'b1}};

  // Quarter-wave magnitude round(127*sin(2*pi*k/256)), k = 0..63; the k = 64 peak is handled separately.
  localparam logic [6:0] SINE_Q [64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
  };

  function automatic logic [DW-1:0] sample_fn(
    input logic [2:0]    mode,
    input logic [DW-1:0] idx,
    input logic [DW-1:0] level
  );
    logic [5:0]    addr;
    logic [6:0]    mag;
    logic [7:0]    s8;
    logic [DW-1:0] wide;
    logic [DW-1:0] tri_v;
    addr = idx[DW-3 -: 6];
    // Falling quarters read the table backwards; address 0 there is the peak itself.
    if (idx[DW-2]) begin
      addr = 6'd0 - addr;
    end else begin
      addr = addr;
    end
    if (idx[DW-2] && (addr == 6'd0)) begin
      mag = 7'd127;
    end else begin
      mag = SINE_Q[addr];
    end
    s8 = {1'b1, mag};
    if (idx[DW-1]) begin
      s8 = ~s8;
    end else begin
      s8 = s8;
    end
    wide  = DW'(s8) << (DW - 8);
    tri_v = {idx[DW-2:0], 1'b0};
    case (mode)
      MODE_SINE: sample_fn = wide;
      MODE_SAW:  sample_fn = idx;
      MODE_TRI:  sample_fn = idx[DW-1] ? ~tri_v : tri_v;
      MODE_SQR:  sample_fn = idx[DW-1] ? {DW{1'b0}} : {DW{1'b1}};
      MODE_DC:   sample_fn = level;
      default:   sample_fn = {DW{1'b0}};
    endcase
  endfunction

  logic [DW-1:0]  cnt_r;
  logic [DW-1:0]  cnt_nxt_s;
  logic           boundary_s;

  logic [2:0]     sh_mode_r  [NCH];
  logic [PW-1:0]  sh_inc_r   [NCH];
  logic [NCH-1:0] sh_pclr_r;
  logic [2:0]     act_mode_r [NCH];
  logic [PW-1:0]  act_inc_r  [NCH];
  logic [PW-1:0]  acc_r      [NCH];
  logic [DW-1:0]  duty_r     [NCH];

  logic [PW:0]    sum_s      [NCH];
  logic [PW-1:0]  acc_nxt_s  [NCH];
  logic [DW-1:0]  duty_nxt_s [NCH];
  logic [NCH-1:0] carry_s;
  logic [NCH-1:0] wr_hit_s;
  logic [NCH-1:0] pwm_nxt_s;

  assign boundary_s = (cnt_r == CNT_MAX);

  // Per-channel next phase, wrap detection, next duty and next PWM level.
  always_comb begin
    cnt_nxt_s = cnt_r + DW'(1);
    for (int n = 0; n < NCH; n++) begin
      sum_s[n]    = {1'b0, acc_r[n]} + {1'b0, act_inc_r[n]};
      wr_hit_s[n] = cfg.cfg_we & (cfg.cfg_ch == 3'(n));
      if (sh_pclr_r[n]) begin
        acc_nxt_s[n] = {PW{1'b0}};
        carry_s[n]   = 1'b0;
      end else if (act_mode_r[n] == MODE_DC) begin
        acc_nxt_s[n] = acc_r[n];
        carry_s[n]   = 1'b0;
      end else begin
        acc_nxt_s[n] = sum_s[n][PW-1:0];
        carry_s[n]   = sum_s[n][PW];
      end
      duty_nxt_s[n] = sample_fn(sh_mode_r[n], acc_nxt_s[n][PW-1 -: DW], sh_inc_r[n][PW-1 -: DW]);
      if (boundary_s) begin
        pwm_nxt_s[n] = (cnt_nxt_s < duty_nxt_s[n]);
      end else begin
        pwm_nxt_s[n] = (cnt_nxt_s < duty_r[n]);
      end
    end
  end

  // Free-running frame counter and the frame-start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {DW{1'b0}};
      frame <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      frame <= boundary_s;
    end
  end

  // Shadow config; a pending phase clear stays set until a boundary consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_pclr_r <= {NCH{1'b0}};
      for (int n = 0; n < NCH; n++) begin
        sh_mode_r[n] <= 3'd0;
        sh_inc_r[n]  <= {PW{1'b0}};
      end
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (wr_hit_s[n]) begin
          sh_mode_r[n] <= cfg.cfg_mode;
          sh_inc_r[n]  <= cfg.cfg_inc;
        end
        if (boundary_s) begin
          sh_pclr_r[n] <= wr_hit_s[n] & cfg.cfg_pclr;
        end else if (wr_hit_s[n]) begin
          sh_pclr_r[n] <= sh_pclr_r[n] | cfg.cfg_pclr;
        end
      end
    end
  end

  // Boundary update of active config, phase, duty and wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {NCH{1'b0}};
      for (int n = 0; n < NCH; n++) begin
        act_mode_r[n] <= 3'd0;
        act_inc_r[n]  <= {PW{1'b0}};
        acc_r[n]      <= {PW{1'b0}};
        duty_r[n]     <= {DW{1'b0}};
      end
    end else if (boundary_s) begin
      sync <= carry_s;
      for (int n = 0; n < NCH; n++) begin
        act_mode_r[n] <= sh_mode_r[n];
        act_inc_r[n]  <= sh_inc_r[n];
        acc_r[n]      <= acc_nxt_s[n];
        duty_r[n]     <= duty_nxt_s[n];
      end
    end else begin
      sync <= {NCH{1'b0}};
    end
  end

  // Registered PWM comparator outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= {NCH{1'b0}};
    end else begin
      pwm <= pwm_nxt_s;
    end
  end

endmodule
